rc4_key_search_controller: RTL and testbench

RC4_KEY_SEARCH_CONTROLLER -- requirements
Module: rc4_key_search_controller

---
 rtl/rc4_key_search_controller.sv | 178 +++++++++++++++++
 tb/tb_rc4_key_search_controller.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_key_search_controller.sv
// Sequences the S-init, key-schedule and decrypt sub-blocks over a key range,
// stopping on the first key whose decrypt verdict is clean, on exhaustion, or on a stalled sub-block.
module rc4_key_search_controller #(
  parameter int                   KEY_WIDTH = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_FIRST = 24'h000000,
  parameter logic [KEY_WIDTH-1:0] KEY_LAST  = 24'h3FFFFF,
  parameter int                   TIMEOUT   = 4096
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 init_start,
  output logic                 shuffle_start,
  output logic                 decrypt_start,
  input  logic                 init_finish,
  input  logic                 shuffle_finish,
  input  logic                 decrypt_finish,
  input  logic                 invalid_ascii,
  output logic [KEY_WIDTH-1:0] secret_key,
  output logic [1:0]           s_owner,
  output logic                 busy,
  output logic                 key_found,
  output logic                 key_exhausted,
  output logic                 timeout_err,
  output logic [KEY_WIDTH:0]   attempts,
  output logic [3:0]           dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT_GO, S_INIT_WAIT, S_SHUF_GO, S_SHUF_WAIT,
    S_DEC_GO, S_DEC_WAIT, S_NEXT_KEY, S_FOUND, S_EXHAUSTED, S_ERROR
  } state_t;

  // The watchdog only ever needs to hold 0..TIMEOUT-1.
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]      WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]      WD_ONE  = {{(WD_W-1){1'b0}}, 1'b1};
  localparam logic [KEY_WIDTH-1:0] KEY_ONE = {{(KEY_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [KEY_WIDTH:0]   ATT_ONE = {{KEY_WIDTH{1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [KEY_WIDTH:0]   att_q, att_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [1:0]           owner_q, owner_d;
  logic                 found_q, found_d;
  logic                 exh_q, exh_d;
  logic                 terr_q, terr_d;
  logic                 wd_expired;

  assign wd_expired = (wd_q == WD_LAST);

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    att_d   = att_q;
    wd_d    = wd_q;
    found_d = found_q;
    exh_d   = exh_q;
    terr_d  = terr_q;
    if (abort) begin
      state_d = S_IDLE;
      wd_d    = '0;
      found_d = 1'b0;
      exh_d   = 1'b0;
      terr_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_FOUND, S_EXHAUSTED, S_ERROR: begin
          if (start) begin
            state_d = S_INIT_GO;
            key_d   = KEY_FIRST;
            att_d   = '0;
            found_d = 1'b0;
            exh_d   = 1'b0;
            terr_d  = 1'b0;
          end
        end
        S_INIT_GO: begin
          state_d = S_INIT_WAIT;
          wd_d    = '0;
        end
        S_INIT_WAIT: begin
          if (init_finish) state_d = S_SHUF_GO;
          else if (wd_expired) begin
            state_d = S_ERROR;
            terr_d  = 1'b1;
          end else wd_d = wd_q + WD_ONE;
        end
        S_SHUF_GO: begin
          state_d = S_SHUF_WAIT;
          wd_d    = '0;
        end
        S_SHUF_WAIT: begin
          if (shuffle_finish) state_d = S_DEC_GO;
          else if (wd_expired) begin
            state_d = S_ERROR;
            terr_d  = 1'b1;
          end else wd_d = wd_q + WD_ONE;
        end
        S_DEC_GO: begin
          state_d = S_DEC_WAIT;
          wd_d    = '0;
        end
        S_DEC_WAIT: begin
          // A clean verdict counts the passing key as tested.
          if (decrypt_finish) begin
            if (!invalid_ascii) begin
              state_d = S_FOUND;
              found_d = 1'b1;
              att_d   = att_q + ATT_ONE;
            end else state_d = S_NEXT_KEY;
          end else if (wd_expired) begin
            state_d = S_ERROR;
            terr_d  = 1'b1;
          end else wd_d = wd_q + WD_ONE;
        end
        S_NEXT_KEY: begin
          att_d = att_q + ATT_ONE;
          if (key_q == KEY_LAST) begin
            state_d = S_EXHAUSTED;
            exh_d   = 1'b1;
          end else begin
            key_d   = key_q + KEY_ONE;
            state_d = S_INIT_GO;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    owner_d = 2'd0;
    case (state_d)
      S_INIT_GO, S_INIT_WAIT: owner_d = 2'd1;
      S_SHUF_GO, S_SHUF_WAIT: owner_d = 2'd2;
      S_DEC_GO,  S_DEC_WAIT:  owner_d = 2'd3;
      default:                owner_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      key_q   <= KEY_FIRST;
      att_q   <= '0;
      wd_q    <= '0;
      owner_q <= 2'd0;
      found_q <= 1'b0;
      exh_q   <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      att_q   <= att_d;
      wd_q    <= wd_d;
      owner_q <= owner_d;
      found_q <= found_d;
      exh_q   <= exh_d;
      terr_q  <= terr_d;
    end
  end

  assign init_start    = (state_q == S_INIT_GO);
  assign shuffle_start = (state_q == S_SHUF_GO);
  assign decrypt_start = (state_q == S_DEC_GO);
  assign busy          = !(state_q inside {S_IDLE, S_FOUND, S_EXHAUSTED, S_ERROR});
  assign secret_key    = key_q;
  assign attempts      = att_q;
  assign s_owner       = owner_q;
  assign key_found     = found_q;
  assign key_exhausted = exh_q;
  assign timeout_err   = terr_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_rc4_key_search_controller.sv
// Bench for rc4_key_search_controller: randomized sub-block latencies and passing keys,
// checked against a key-range model of the search outcome.
module tb_rc4_key_search_controller;

  localparam int KW = 8;
  localparam int KF = 0;
  localparam int KL = 9;
  localparam int TO = 16;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0, abort = 1'b0;
  logic r_init_fin = 1'b0, r_shuf_fin = 1'b0, r_dec_fin = 1'b0, r_inv = 1'b0, m_dec_fin = 1'b0;
  logic init_finish, shuffle_finish, decrypt_finish, invalid_ascii;
  logic init_start, shuffle_start, decrypt_start;
  logic [KW-1:0] secret_key;
  logic [1:0] s_owner;
  logic busy, key_found, key_exhausted, timeout_err;
  logic [KW:0] attempts;
  logic [3:0] dbg_state;

  assign init_finish    = r_init_fin;
  assign shuffle_finish = r_shuf_fin;
  assign decrypt_finish = r_dec_fin | m_dec_fin;
  assign invalid_ascii  = r_inv;

  rc4_key_search_controller #(
    .KEY_WIDTH(KW), .KEY_FIRST(8'(KF)), .KEY_LAST(8'(KL)), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .init_start(init_start), .shuffle_start(shuffle_start), .decrypt_start(decrypt_start),
    .init_finish(init_finish), .shuffle_finish(shuffle_finish), .decrypt_finish(decrypt_finish),
    .invalid_ascii(invalid_ascii), .secret_key(secret_key), .s_owner(s_owner), .busy(busy),
    .key_found(key_found), .key_exhausted(key_exhausted), .timeout_err(timeout_err),
    .attempts(attempts), .dbg_state(dbg_state)
  );

  // responder knobs, written only by the main sequence
  int pass_key = -1, max_lat = 2, fix_init_lat = -1, fix_shuf_lat = -1;
  int hang_shuf_key = -1, hang_dec_key = -1;

  // monitor + sub-block responder
  int n_init = 0, n_shuf = 0, n_dec = 0, n_order = 0;
  logic [KW-1:0] obs_key [256];
  bit init_pend = 0, shuf_pend = 0, dec_pend = 0;
  int init_dly = 0, shuf_dly = 0, dec_dly = 0;

  always @(negedge clk) begin
    if (init_start) n_init++;
    if (shuffle_start) begin
      n_shuf++;
      if (!init_finish) n_order++;
    end
    if (decrypt_start) begin
      if (!shuffle_finish) n_order++;
      obs_key[n_dec % 256] = secret_key;
      n_dec++;
    end
    r_init_fin = 1'b0;
    r_shuf_fin = 1'b0;
    r_dec_fin  = 1'b0;
    r_inv      = 1'b0;
    if (!reset_n) begin
      init_pend = 0;
      shuf_pend = 0;
      dec_pend  = 0;
    end else begin
      if (init_pend) begin
        if (init_dly == 0) begin r_init_fin = 1'b1; init_pend = 0; end
        else init_dly--;
      end
      if (shuf_pend) begin
        if (shuf_dly == 0) begin r_shuf_fin = 1'b1; shuf_pend = 0; end
        else shuf_dly--;
      end
      if (dec_pend) begin
        if (dec_dly == 0) begin
          r_dec_fin = 1'b1;
          r_inv = (int'(secret_key) != pass_key);
          dec_pend = 0;
        end else dec_dly--;
      end
      if (init_start) begin
        init_pend = 1;
        init_dly = (fix_init_lat >= 0) ? fix_init_lat : int'($urandom_range(0, max_lat));
      end
      if (shuffle_start && int'(secret_key) != hang_shuf_key) begin
        shuf_pend = 1;
        shuf_dly = (fix_shuf_lat >= 0) ? fix_shuf_lat : int'($urandom_range(0, max_lat));
      end
      if (decrypt_start && int'(secret_key) != hang_dec_key) begin
        dec_pend = 1;
        dec_dly = int'($urandom_range(0, max_lat));
      end
    end
  end

  // scoreboard
  int n_checks = 0, n_fail = 0;
  logic [KW-1:0] exp_q[$];
  bit exp_found;
  int exp_last, exp_n;
  int b_init, b_shuf, b_dec, b_order;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string t);
    check({t, "_starts"}, 32'({init_start, shuffle_start, decrypt_start}), 0);
    check({t, "_owner"}, 32'(s_owner), 0);
    check({t, "_busy"}, 32'(busy), 0);
    check({t, "_flags"}, 32'({key_found, key_exhausted, timeout_err}), 0);
    check({t, "_key"}, 32'(secret_key), KF);
    check({t, "_attempts"}, 32'(attempts), 0);
  endtask

  task automatic snap();
    b_init = n_init; b_shuf = n_shuf; b_dec = n_dec; b_order = n_order;
  endtask

  task automatic start_search();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("go_init_start", 32'(init_start), 1);
    check("go_owner", 32'(s_owner), 1);
    check("go_flags_clear", 32'({key_found, key_exhausted, timeout_err}), 0);
  endtask

  // Model: keys KF.. are tried in order until the passing key or KL.
  task automatic begin_search(input int p);
    pass_key  = p;
    exp_found = (p >= KF && p <= KL);
    exp_last  = exp_found ? p : KL;
    exp_n     = exp_last - KF + 1;
    exp_q.delete();
    for (int k = KF; k <= exp_last; k++) exp_q.push_back(KW'(k));
    snap();
    start_search();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk); n++; end
    check("wait_idle_bound", 32'(busy), 0);
  endtask

  task automatic end_search();
    int got_n;
    wait_idle(600);
    check("found", 32'(key_found), 32'(exp_found));
    check("exhausted", 32'(key_exhausted), 32'(!exp_found));
    check("timeout_err", 32'(timeout_err), 0);
    check("final_key", 32'(secret_key), exp_last);
    check("attempts", 32'(attempts), exp_n);
    check("owner_idle", 32'(s_owner), 0);
    check("init_pulses", n_init - b_init, exp_n);
    check("shuf_pulses", n_shuf - b_shuf, exp_n);
    got_n = n_dec - b_dec;
    check("dec_pulses", got_n, exp_n);
    check("stage_order", n_order - b_order, 0);
    for (int i = 0; i < got_n && exp_q.size() > 0; i++)
      check("sb_key", 32'(obs_key[(b_dec + i) % 256]), 32'(exp_q.pop_front()));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int n, wcnt;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    reset_n = 1'b1;

    max_lat = 2; begin_search(5); end_search();
    max_lat = 3; begin_search(100); end_search();
    repeat (6) begin
      max_lat = int'($urandom_range(0, 6));
      begin_search(int'($urandom_range(0, 12)));
      end_search();
    end

    // finish on the last watchdog cycle is honoured
    fix_shuf_lat = TO - 1; max_lat = 1;
    begin_search(2); end_search();
    fix_shuf_lat = -1;

    // shuffle never finishes
    hang_shuf_key = KF;
    begin_search(100);
    n = 0;
    while (!shuffle_start && n < 100) begin @(negedge clk); n++; end
    check("to_saw_shuffle", 32'(shuffle_start), 1);
    wcnt = 0;
    while (wcnt < 40) begin
      @(negedge clk);
      if (timeout_err) break;
      wcnt++;
    end
    check("to_wait_cycles", wcnt, TO);
    check("to_flag", 32'(timeout_err), 1);
    check("to_owner", 32'(s_owner), 0);
    check("to_busy", 32'(busy), 0);
    hang_shuf_key = -1;

    // abort together with a clean decrypt verdict
    hang_dec_key = 3; max_lat = 2;
    begin_search(100);
    n = 0;
    while (!(decrypt_start && secret_key == 8'd3) && n < 300) begin @(negedge clk); n++; end
    check("ab_saw_decrypt", 32'(decrypt_start), 1);
    @(negedge clk); m_dec_fin = 1'b1; abort = 1'b1;
    @(negedge clk); m_dec_fin = 1'b0; abort = 1'b0;
    check("ab_busy", 32'(busy), 0);
    check("ab_found", 32'(key_found), 0);
    check("ab_owner", 32'(s_owner), 0);
    check("ab_key_held", 32'(secret_key), 3);
    check("ab_attempts_held", 32'(attempts), 3);
    snap();
    repeat (20) @(negedge clk);
    check("ab_no_pulses", (n_init - b_init) + (n_shuf - b_shuf) + (n_dec - b_dec), 0);
    hang_dec_key = -1;

    // abort beats start in IDLE
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("ab_start_busy", 32'(busy), 0);
    check("ab_start_no_init", 32'(init_start), 0);

    // spurious decrypt_finish while waiting on init
    fix_init_lat = 4;
    begin_search(int'($urandom_range(0, KL)));
    @(negedge clk); m_dec_fin = 1'b1;
    @(negedge clk); m_dec_fin = 1'b0;
    check("sp_owner", 32'(s_owner), 1);
    check("sp_no_shuffle", 32'(shuffle_start), 0);
    end_search();
    fix_init_lat = -1;

    // reset mid-search during shuffle wait at key 7
    hang_shuf_key = 7;
    begin_search(100);
    n = 0;
    while (!(shuffle_start && secret_key == 8'd7) && n < 600) begin @(negedge clk); n++; end
    check("rs_saw_key7", 32'(secret_key), 7);
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    check_reset_values("rst_mid");
    hang_shuf_key = -1;

    max_lat = 4; begin_search(int'($urandom_range(0, KL))); end_search();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
